// File: rtl/output_tile_drain.sv
`default_nettype none
//==============================================================================
// Module      : output_tile_drain
// Description : Captures a full HEIGHT x WIDTH output tile from the shared
//               adder bus in one cycle, then streams it downstream one row per
//               beat over a valid/ready interface.
// Revision    : 1.0 - initial release
//==============================================================================

`ifndef OUT_BIN_LEN
`define OUT_BIN_LEN 16
`endif
`ifndef OUTPUT_HEIGHT
`define OUTPUT_HEIGHT 4
`endif
`ifndef OUTPUT_WIDTH
`define OUTPUT_WIDTH 4
`endif

module output_tile_drain #(
    parameter int BIN_LEN = `OUT_BIN_LEN,
    parameter int HEIGHT  = `OUTPUT_HEIGHT,
    parameter int WIDTH   = `OUTPUT_WIDTH,
    parameter int CNT_W   = 16,
    parameter int IDX_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                                      clock_i,
    input  logic                                      reset_i,
    input  logic [HEIGHT-1:0][WIDTH-1:0][BIN_LEN-1:0] bus_vals_i,
    input  logic                                      capture_req_i,
    output logic                                      capture_ack_o,
    output logic [WIDTH*BIN_LEN-1:0]                  out_row_o,
    output logic [IDX_W-1:0]                          out_row_idx_o,
    output logic                                      out_valid_o,
    output logic                                      out_last_o,
    input  logic                                      out_ready_i,
    output logic                                      busy_o,
    output logic [CNT_W-1:0]                          tile_count_o
);

    localparam logic [IDX_W-1:0] c_LAST_ROW = IDX_W'(HEIGHT - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                                  state_q;
    logic [HEIGHT-1:0][WIDTH-1:0][BIN_LEN-1:0] buffer_q;
    logic [IDX_W-1:0]                        row_ptr_q;
    logic [CNT_W-1:0]                        tile_count_q;

    logic w_beat;
    logic w_last_beat;
    logic w_can_capture;
    logic w_capture;

    // Handshake decode: a new tile may land while idle or on the final beat.
    always_comb begin
        w_beat        = (state_q == S_DRAIN) && out_ready_i;
        w_last_beat   = w_beat && (row_ptr_q == c_LAST_ROW);
        w_can_capture = (state_q == S_IDLE) || w_last_beat;
        w_capture     = capture_req_i && w_can_capture;
    end

    // Drain FSM: captures the tile, walks the row pointer, chains tiles.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            buffer_q  <= '0;
            row_ptr_q <= '0;
        end else if (w_capture) begin
            // The bus is only sampled here, so a floating bus never enters.
            state_q   <= S_DRAIN;
            buffer_q  <= bus_vals_i;
            row_ptr_q <= '0;
        end else if (w_last_beat) begin
            state_q   <= S_IDLE;
            row_ptr_q <= '0;
        end else if (w_beat) begin
            row_ptr_q <= row_ptr_q + 1'b1;
        end
    end

    // Completed-tile counter; wraps naturally at its width.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            tile_count_q <= '0;
        end else if (w_last_beat) begin
            tile_count_q <= tile_count_q + CNT_W'(1);
        end
    end

    // A single-row tile has no pointer to select with.
    generate
        if (HEIGHT == 1) begin : g_single_row
            assign out_row_o = buffer_q[0];
        end else begin : g_multi_row
            assign out_row_o = buffer_q[row_ptr_q];
        end
    endgenerate

    assign capture_ack_o = w_capture;
    assign out_row_idx_o = row_ptr_q;
    assign out_valid_o   = (state_q == S_DRAIN);
    assign out_last_o    = (state_q == S_DRAIN) && (row_ptr_q == c_LAST_ROW);
    assign busy_o        = (state_q == S_DRAIN);
    assign tile_count_o  = tile_count_q;

endmodule

`default_nettype wire

// File: tb/tb_output_tile_drain.sv
`default_nettype none
//==============================================================================
// Module      : tb_output_tile_drain
// Description : Directed self-checking bench for output_tile_drain.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps

module tb_output_tile_drain;

    int checks;
    int failures;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 4x4 tile of 16-bit values
    logic                        rst0;
    logic [3:0][3:0][15:0]       bus0;
    logic                        req0;
    logic                        ack0;
    logic [63:0]                 row0;
    logic [1:0]                  idx0;
    logic                        valid0;
    logic                        last0;
    logic                        ready0;
    logic                        busy0;
    logic [15:0]                 cnt0;

    output_tile_drain #(.BIN_LEN(16), .HEIGHT(4), .WIDTH(4), .CNT_W(16)) u_dut0 (
        .clock_i       (clk),
        .reset_i       (rst0),
        .bus_vals_i    (bus0),
        .capture_req_i (req0),
        .capture_ack_o (ack0),
        .out_row_o     (row0),
        .out_row_idx_o (idx0),
        .out_valid_o   (valid0),
        .out_last_o    (last0),
        .out_ready_i   (ready0),
        .busy_o        (busy0),
        .tile_count_o  (cnt0)
    );

    // Single-row instance: HEIGHT=1, used for the counter wrap
    logic                        rst1;
    logic [0:0][1:0][7:0]        bus1;
    logic                        req1;
    logic                        ack1;
    logic [15:0]                 row1;
    logic [0:0]                  idx1;
    logic                        valid1;
    logic                        last1;
    logic                        ready1;
    logic                        busy1;
    logic [15:0]                 cnt1;

    output_tile_drain #(.BIN_LEN(8), .HEIGHT(1), .WIDTH(2), .CNT_W(16)) u_dut1 (
        .clock_i       (clk),
        .reset_i       (rst1),
        .bus_vals_i    (bus1),
        .capture_req_i (req1),
        .capture_ack_o (ack1),
        .out_row_o     (row1),
        .out_row_idx_o (idx1),
        .out_valid_o   (valid1),
        .out_last_o    (last1),
        .out_ready_i   (ready1),
        .busy_o        (busy1),
        .tile_count_o  (cnt1)
    );

    // Tile t holds value t*256 + 16*r + c at row r, column c
    function automatic logic [63:0] exp_row(input int t, input int r);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) v[c*16 +: 16] = 16'(t*256 + 16*r + c);
        return v;
    endfunction

    task automatic set_bus(input int t);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bus0[r][c] = 16'(t*256 + 16*r + c);
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        req0 = 1'b0; req1 = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
        bus0 = '0; bus1 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || last0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags valid=%b busy=%b last=%b required 0 0 0", valid0, busy0, last0);
        end
        checks++;
        if (row0 !== 64'h0 || idx0 !== 2'd0 || cnt0 !== 16'd0 || ack0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_data row=%h idx=%0d cnt=%0d ack=%b required 0 0 0 0", row0, idx0, cnt0, ack0);
        end
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_bus(0); req0 = 1'b1; ready0 = 1'b1;
        #1;
        checks++;
        if (ack0 !== 1'b1) begin
            failures++;
            $display("FAIL single_ack got=%b required=1", ack0);
        end
        @(posedge clk); #1;
        req0 = 1'b0; bus0 = 'z;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (valid0 !== 1'b1 || idx0 !== 2'(r) || row0 !== exp_row(0, r) ||
                last0 !== (r == 3) || busy0 !== 1'b1 || ack0 !== 1'b0) begin
                failures++;
                $display("FAIL single_row%0d valid=%b idx=%0d row=%h last=%b busy=%b ack=%b required 1 %0d %h %b 1 0",
                         r, valid0, idx0, row0, last0, busy0, ack0, r, exp_row(0, r), (r == 3));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 16'd1) begin
            failures++;
            $display("FAIL single_done valid=%b busy=%b cnt=%0d required 0 0 1", valid0, busy0, cnt0);
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] pat;
        int exp_r;
        bit done;
        pat = 9'b1_0010_1001; // accepted on cycles 0,3,5,8
        exp_r = 0;
        done = 1'b0;
        @(negedge clk);
        set_bus(1); req0 = 1'b1; ready0 = 1'b0;
        @(posedge clk); #1;
        req0 = 1'b0; bus0 = 'z;
        for (int k = 0; k < 9 && !done; k++) begin
            ready0 = pat[k];
            checks++;
            if (valid0 !== 1'b1 || idx0 !== 2'(exp_r) || row0 !== exp_row(1, exp_r) || last0 !== (exp_r == 3)) begin
                failures++;
                $display("FAIL bp_cycle%0d valid=%b idx=%0d row=%h last=%b required 1 %0d %h %b",
                         k, valid0, idx0, row0, last0, exp_r, exp_row(1, exp_r), (exp_r == 3));
            end
            @(posedge clk); #1;
            if (pat[k]) begin
                if (exp_r == 3) done = 1'b1;
                exp_r++;
            end
        end
        ready0 = 1'b1;
        checks++;
        if (valid0 !== 1'b0 || cnt0 !== 16'd2 || !done) begin
            failures++;
            $display("FAIL bp_done valid=%b cnt=%0d rows_seen=%0d required 0 2 4", valid0, cnt0, exp_r);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_bus(2); req0 = 1'b1; ready0 = 1'b1;
        @(posedge clk); #1;
        set_bus(3); // req stays high: next tile waits on the bus
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (ack0 !== (r == 3) || idx0 !== 2'(r) || row0 !== exp_row(2, r)) begin
                failures++;
                $display("FAIL b2b_row%0d ack=%b idx=%0d row=%h required %b %0d %h",
                         r, ack0, idx0, row0, (r == 3), r, exp_row(2, r));
            end
            @(posedge clk); #1;
        end
        req0 = 1'b0; bus0 = 'z;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (valid0 !== 1'b1 || idx0 !== 2'(r) || row0 !== exp_row(3, r)) begin
                failures++;
                $display("FAIL b2b_next_row%0d valid=%b idx=%0d row=%h required 1 %0d %h",
                         r, valid0, idx0, row0, r, exp_row(3, r));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 16'd4) begin
            failures++;
            $display("FAIL b2b_done valid=%b busy=%b cnt=%0d required 0 0 4", valid0, busy0, cnt0);
        end
    endtask

    task automatic test_bus_xz();
        @(negedge clk);
        req0 = 1'b0; bus0 = 'x;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus0 = 'z;
        repeat (2) @(posedge clk);
        #1;
        // Idle output shows buffer row 0, which must still be tile 3
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || ack0 !== 1'b0 || row0 !== exp_row(3, 0)) begin
            failures++;
            $display("FAIL bus_xz valid=%b busy=%b ack=%b row=%h required 0 0 0 %h",
                     valid0, busy0, ack0, row0, exp_row(3, 0));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_bus(4); req0 = 1'b1; ready0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; bus0 = 'z;
        repeat (2) @(posedge clk); // rows 0 and 1 accepted
        #1;
        checks++;
        if (idx0 !== 2'd2 || cnt0 !== 16'd4) begin
            failures++;
            $display("FAIL rst_mid_pre idx=%0d cnt=%0d required 2 4", idx0, cnt0);
        end
        #2 rst0 = 1'b1;
        #1;
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 16'd0 || row0 !== 64'h0 || idx0 !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid valid=%b busy=%b cnt=%0d row=%h idx=%0d required 0 0 0 0 0",
                     valid0, busy0, cnt0, row0, idx0);
        end
        @(negedge clk);
        rst0 = 1'b0;
        set_bus(5); req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; bus0 = 'z;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (valid0 !== 1'b1 || idx0 !== 2'(r) || row0 !== exp_row(5, r)) begin
                failures++;
                $display("FAIL rst_fresh_row%0d valid=%b idx=%0d row=%h required 1 %0d %h",
                         r, valid0, idx0, row0, r, exp_row(5, r));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cnt0 !== 16'd1 || valid0 !== 1'b0) begin
            failures++;
            $display("FAIL rst_fresh_done cnt=%0d valid=%b required 1 0", cnt0, valid0);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        bus1[0][0] = 8'h3C; bus1[0][1] = 8'hA5;
        req1 = 1'b1; ready1 = 1'b1;
        @(posedge clk); #1; // first tile captured
        checks++;
        if (valid1 !== 1'b1 || last1 !== 1'b1 || idx1 !== 1'b0 || row1 !== 16'hA53C || ack1 !== 1'b1) begin
            failures++;
            $display("FAIL h1_beat valid=%b last=%b idx=%0d row=%h ack=%b required 1 1 0 a53c 1",
                     valid1, last1, idx1, row1, ack1);
        end
        @(posedge clk); #1;
        checks++;
        if (cnt1 !== 16'd1 || valid1 !== 1'b1) begin
            failures++;
            $display("FAIL h1_first cnt=%0d valid=%b required 1 1", cnt1, valid1);
        end
        repeat (65535) @(posedge clk);
        #1;
        checks++;
        if (cnt1 !== 16'd0) begin
            failures++;
            $display("FAIL wrap_zero cnt=%0d required 0", cnt1);
        end
        @(posedge clk); #1;
        checks++;
        if (cnt1 !== 16'd1) begin
            failures++;
            $display("FAIL wrap_one cnt=%0d required 1", cnt1);
        end
        req1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cnt1 !== 16'd2 || valid1 !== 1'b0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL h1_stop cnt=%0d valid=%b busy=%b required 2 0 0", cnt1, valid1, busy1);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_bus_xz();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
